// File: rtl/control_wall.sv
`default_nettype none
// ============================================================================
// Module   : control_wall
// Purpose  : Sequences one wall step per FRAMES_PER_STEP frames: erase the
//            wall, move it left (flagging wrap and score), then redraw it.
// Revision : 1.0
// ============================================================================
module control_wall #(
    parameter int FRAMES_PER_STEP = 4,
    parameter int WALL_X_SPEED    = 4,
    parameter int DRAW_TIMEOUT    = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [7:0] wall_x,
    input  logic       draw_done,
    output logic [1:0] cur_state,
    output logic       draw_start,
    output logic       ld_wall,
    output logic       wall_wrap,
    output logic       score_inc,
    output logic       draw_err
);

    localparam logic [1:0]  c_st_update  = 2'd0;
    localparam logic [1:0]  c_st_del     = 2'd1;
    localparam logic [1:0]  c_st_draw    = 2'd2;
    localparam logic [1:0]  c_st_wait    = 2'd3;
    localparam logic [7:0]  c_frame_last = 8'(FRAMES_PER_STEP - 1);
    localparam logic [7:0]  c_speed      = 8'(WALL_X_SPEED);
    localparam logic [15:0] c_to_last    = 16'(DRAW_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_frame_cnt;
    logic [15:0] r_to_cnt;
    logic        r_draw_start;
    logic        r_wall_wrap;
    logic        r_score_inc;
    logic        r_draw_err;
    logic        w_phase_end;

    // A phase ends on draw_done or on its last allowed cycle, whichever first.
    assign w_phase_end = draw_done || (r_to_cnt == c_to_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_wait;
            r_frame_cnt  <= 8'd0;
            r_to_cnt     <= 16'd0;
            r_draw_start <= 1'b0;
            r_wall_wrap  <= 1'b0;
            r_score_inc  <= 1'b0;
            r_draw_err   <= 1'b0;
        end else begin
            r_draw_start <= 1'b0;
            r_wall_wrap  <= 1'b0;
            r_score_inc  <= 1'b0;
            case (r_state)
                c_st_wait: begin
                    if (enable && frame_tick) begin
                        if (r_frame_cnt == c_frame_last) begin
                            r_frame_cnt  <= 8'd0;
                            r_state      <= c_st_del;
                            r_draw_start <= 1'b1;
                            r_to_cnt     <= 16'd0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                end
                c_st_del: begin
                    if (w_phase_end) begin
                        if (!draw_done) r_draw_err <= 1'b1;
                        r_state     <= c_st_update;
                        // Sampled before UPDATE so the flag lines up with ld_wall.
                        r_wall_wrap <= (wall_x < c_speed);
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                c_st_update: begin
                    r_state      <= c_st_draw;
                    r_draw_start <= 1'b1;
                    r_to_cnt     <= 16'd0;
                    r_score_inc  <= r_wall_wrap;
                end
                c_st_draw: begin
                    if (w_phase_end) begin
                        if (!draw_done) r_draw_err <= 1'b1;
                        r_state <= c_st_wait;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                default: r_state <= c_st_wait;
            endcase
        end
    end

    assign cur_state  = r_state;
    assign draw_start = r_draw_start;
    assign ld_wall    = (r_state == c_st_update);
    assign wall_wrap  = r_wall_wrap;
    assign score_inc  = r_score_inc;
    assign draw_err   = r_draw_err;

endmodule
`default_nettype wire

// File: doc/control_wall.md
Name: control_wall

Overview:
- FSM that sequences the wall datapath once per game step: erase the old wall, update its x position, then redraw it.
- Drives the datapath's 2-bit cur_state and qualifies each phase with one-cycle pulses.
- Paces steps from the 60 Hz frame tick. Detects wall wrap-around at the left edge and flags a score increment.
- Sits between the top-level game FSM (enable, frame tick) and the wall datapath / rectangle drawer (draw_start, draw_done).

Parameters:
- FRAMES_PER_STEP, 4, frame ticks per wall step; legal 1..255
- WALL_X_SPEED, 4, pixels the wall moves per step; used for wrap detection
- DRAW_TIMEOUT, 2048, maximum cycles to wait for draw_done before aborting a phase; legal 2..65535

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  game running; sampled only in WAIT
- frame_tick  in  1  one-cycle pulse per video frame
- wall_x  in  8  current wall x position from the datapath
- draw_done  in  1  one-cycle pulse from the rectangle drawer when the current rectangle is finished
- cur_state  out  2  datapath state select: 0=UPDATE_WALL, 1=DEL_WALL, 2=DRAW_WALL, 3=WAIT
- draw_start  out  1  one-cycle pulse on the first cycle of DEL_WALL and of DRAW_WALL
- ld_wall  out  1  one-cycle pulse in UPDATE_WALL; datapath loads wall_x - WALL_X_SPEED, or restarts the wall if wall_wrap is high
- wall_wrap  out  1  one-cycle pulse, coincident with ld_wall, when wall_x < WALL_X_SPEED
- score_inc  out  1  one-cycle pulse, the cycle after wall_wrap
- draw_err  out  1  sticky flag set on any draw timeout; cleared only by reset

Behaviour:
- Reset (sync, active-high, dominant in every state):
  - state=WAIT, so cur_state=3
  - frame counter=0, timeout counter=0
  - all pulse outputs=0, draw_err=0
  - A reset during DEL or DRAW abandons the drawer mid-rectangle. The next DEL re-erases whatever is on screen.
- WAIT (3):
  - On each frame_tick with enable=1, the frame counter increments.
  - When frame_tick arrives with counter==FRAMES_PER_STEP-1: counter clears and the FSM moves to DEL next cycle.
  - With enable=0, the counter holds its value and frame_tick is ignored.
- DEL_WALL (1):
  - draw_start=1 on the entry cycle only.
  - Timeout counter clears on entry and increments every cycle.
  - draw_done=1 -> UPDATE next cycle.
  - Counter reaches DRAW_TIMEOUT-1 without draw_done -> set draw_err, go to UPDATE anyway.
  - A draw_done arriving on the entry cycle is accepted.
- UPDATE_WALL (0):
  - Lasts exactly one cycle; ld_wall=1.
  - wall_wrap = (wall_x < WALL_X_SPEED), as an 8-bit unsigned compare, so the datapath never underflows.
  - Next state is DRAW. score_inc pulses in DRAW's first cycle if wall_wrap was set.
- DRAW_WALL (2):
  - Same draw_start, timeout and draw_err rules as DEL.
  - draw_done or timeout -> WAIT.
- Ignored inputs:
  - frame_tick outside WAIT is ignored and not counted, so a late draw drops frames rather than queueing steps.
  - draw_done outside DEL/DRAW is ignored.
- Output timing: all outputs are registered or decoded from registered state. cur_state changes only on a clk edge.
- Step latency: last qualifying frame_tick -> cur_state=1 is 1 cycle. Minimum full step (instant draw_done) is WAIT→DEL→UPDATE→DRAW→WAIT, 4 cycles after the tick.
- Wrap of the frame counter is impossible: it clears at FRAMES_PER_STEP-1.

Test Plan:
- Reset then enable=1, FRAMES_PER_STEP=4, ticks every 10 cycles, drawer returns draw_done 3 cycles after draw_start -> cur_state stays 3 until the 4th tick, then sequence 1,0,2,3. Exactly two draw_start pulses and one ld_wall per step.
- wall_x=100, then wall_x=3 with WALL_X_SPEED=4 -> no wall_wrap for 100; for 3, wall_wrap with ld_wall, and score_inc one cycle later.
- enable=0 for 6 ticks mid-count (counter=2), then enable=1 -> step fires on the 2nd tick after re-enable.
- DRAW_TIMEOUT=16, draw_done never asserted in DEL -> after 16 cycles state goes to UPDATE, draw_err=1 and stays 1 through later successful steps until reset.
- reset asserted during DRAW with draw_done pending -> next cycle cur_state=3, draw_err=0, no ld_wall/score_inc; a draw_done arriving afterwards is ignored.
- frame_tick pulses during DEL/DRAW -> not counted: the next step needs the full FRAMES_PER_STEP ticks in WAIT.
